// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch FSM and its next-PC helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam logic [63:0] PC_INCR           = 64'd4;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_0000;
    localparam int          OPCODE_MSB        = 31;
    localparam int          OPCODE_LSB        = 21;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational branch decision and next-PC select.
// The immediate is a word offset, so it is scaled by 4 before the add.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [63:0] pc,
    input  logic [63:0] branchImm,
    input  logic        unconditionalBranch,
    input  logic        conditionalBranch,
    input  logic        zero,
    output logic [63:0] nextPc
);

    logic taken;

    // An unconditional branch wins regardless of the zero flag.
    assign taken  = unconditionalBranch | (conditionalBranch & zero);
    assign nextPc = taken ? (pc + (branchImm << 2)) : (pc + PC_INCR);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches words over a req/ready handshake and holds
// each word for the decoder until execution acknowledges it.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] PC_RESET  = 64'h0,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic         CLK,
    input  logic         Reset_L,
    output logic         imem_req,
    output logic [63:0]  imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instruction,
    output logic [10:0]  opcode,
    output logic         instr_valid,
    output logic [63:0]  pc,
    input  logic         exec_ack,
    input  logic         unconditionalBranch,
    input  logic         conditionalBranch,
    input  logic         zero,
    input  logic [63:0]  branchImm,
    output logic         halted,
    output logic [31:0]  retired,
    output fetch_state_e fsmState
);

    // Handshakes: a memory transfer completes on the rising edge where
    // imem_req and imem_ready are both high; an instruction retires on the
    // rising edge where instr_valid and exec_ack are both high. imem_ready and
    // exec_ack are don't-care whenever the matching request/valid is low.

    fetch_state_e state, nextState;
    logic [63:0]  nextPc;
    logic         fetchDone;
    logic         issueDone;

    next_pc_calc u_next_pc_calc (
        .pc                  (pc),
        .branchImm           (branchImm),
        .unconditionalBranch (unconditionalBranch),
        .conditionalBranch   (conditionalBranch),
        .zero                (zero),
        .nextPc              (nextPc)
    );

    assign fetchDone = (state == FETCH) && imem_ready;
    assign issueDone = (state == ISSUE) && exec_ack;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE: begin
                nextState = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    nextState = (imem_rdata == HALT_WORD) ? HALT : ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (exec_ack) begin
                    nextState = FETCH;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pc          <= PC_RESET;
            instruction <= 32'h0;
            retired     <= 32'h0;
        end else begin
            if (fetchDone) begin
                instruction <= imem_rdata;
            end
            if (issueDone) begin
                pc      <= nextPc;
                retired <= retired + 32'd1;
            end
        end
    end

    assign imem_addr = pc;
    assign opcode    = instruction[OPCODE_MSB:OPCODE_LSB];
    assign fsmState  = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed handshake, branch, wrap,
// halt and reset scenarios followed by randomized fetch/execute traffic.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam logic [63:0] PC_RESET = 64'h0;

    logic         CLK = 1'b0;
    logic         Reset_L = 1'b0;
    logic         imem_req;
    logic [63:0]  imem_addr;
    logic         imem_ready = 1'b0;
    logic [31:0]  imem_rdata = 32'h0;
    logic [31:0]  instruction;
    logic [10:0]  opcode;
    logic         instr_valid;
    logic [63:0]  pc;
    logic         exec_ack = 1'b0;
    logic         unconditionalBranch = 1'b0;
    logic         conditionalBranch = 1'b0;
    logic         zero = 1'b0;
    logic [63:0]  branchImm = 64'h0;
    logic         halted;
    logic [31:0]  retired;
    fetch_state_e fsmState;

    instruction_fetch #(.PC_RESET(PC_RESET)) dut (
        .CLK                 (CLK),
        .Reset_L             (Reset_L),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ready          (imem_ready),
        .imem_rdata          (imem_rdata),
        .instruction         (instruction),
        .opcode              (opcode),
        .instr_valid         (instr_valid),
        .pc                  (pc),
        .exec_ack            (exec_ack),
        .unconditionalBranch (unconditionalBranch),
        .conditionalBranch   (conditionalBranch),
        .zero                (zero),
        .branchImm           (branchImm),
        .halted              (halted),
        .retired             (retired),
        .fsmState            (fsmState)
    );

    always #5 CLK = ~CLK;

    // Reference model: architectural PC, retire count and outstanding words.
    int          nChecks = 0;
    int          nPass = 0;
    logic [63:0] mPc;
    logic [31:0] mRetired;
    logic [31:0] expInstrQ[$];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, then releases it
    // on a falling edge. Optionally holds imem_ready high through IDLE.
    task automatic resetPulse(input logic lateReady);
        #2 Reset_L = 1'b0;
        #1;
        mPc      = PC_RESET;
        mRetired = 32'h0;
        expInstrQ.delete();
        checkVal("rst_req", imem_req, 0);
        checkVal("rst_ivalid", instr_valid, 0);
        checkVal("rst_halted", halted, 0);
        checkVal("rst_addr", imem_addr, PC_RESET);
        checkVal("rst_instr", instruction, 0);
        checkVal("rst_opcode", opcode, 0);
        checkVal("rst_retired", retired, 0);
        @(negedge CLK);
        Reset_L = 1'b1;
        exec_ack = 1'b0;
        imem_ready = lateReady;
        imem_rdata = 32'hDEAD_BEEF;
        checkVal("idle_req", imem_req, 0);
        @(negedge CLK);
        imem_ready = 1'b0;
        checkVal("idle_ready_ignored", instr_valid, 0);
    endtask

    // Starts at a falling edge with the DUT in FETCH; ready arrives after waitCycles.
    task automatic fetchInstr(input logic [31:0] word, input int waitCycles);
        logic [31:0] expOp;
        for (int i = 0; i <= waitCycles; i++) begin
            checkVal("fetch_req", imem_req, 1);
            checkVal("fetch_addr", imem_addr, mPc);
            checkVal("fetch_ivalid", instr_valid, 0);
            imem_ready = (i == waitCycles);
            imem_rdata = (i == waitCycles) ? word : $urandom;
            exec_ack   = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        imem_ready = 1'b0;
        exec_ack   = 1'b0;
        checkVal("post_fetch_req", imem_req, 0);
        if (word == DEFAULT_HALT_WORD) begin
            checkVal("halt_flag", halted, 1);
            checkVal("halt_ivalid", instr_valid, 0);
        end else begin
            expOp = word >> 21;
            checkVal("issue_valid", instr_valid, 1);
            checkVal("issue_instr", instruction, word);
            checkVal("issue_opcode", opcode, expOp);
            checkVal("issue_pc", pc, mPc);
            expInstrQ.push_back(word);
        end
    endtask

    // Starts at a falling edge with the DUT in ISSUE; ack arrives after waitCycles.
    task automatic ackInstr(input int waitCycles, input logic ub, input logic cb,
                            input logic z, input logic [63:0] imm);
        logic [31:0] expWord;
        logic [31:0] expOp;
        logic        taken;
        expWord = (expInstrQ.size() > 0) ? expInstrQ.pop_front() : 32'h0;
        expOp   = expWord >> 21;
        for (int i = 0; i <= waitCycles; i++) begin
            checkVal("hold_valid", instr_valid, 1);
            checkVal("hold_instr", instruction, expWord);
            checkVal("hold_opcode", opcode, expOp);
            checkVal("hold_pc", pc, mPc);
            exec_ack            = (i == waitCycles);
            unconditionalBranch = (i == waitCycles) ? ub : 1'($urandom_range(0, 1));
            conditionalBranch   = (i == waitCycles) ? cb : 1'($urandom_range(0, 1));
            zero                = (i == waitCycles) ? z  : 1'($urandom_range(0, 1));
            branchImm           = (i == waitCycles) ? imm : {$urandom, $urandom};
            imem_ready          = 1'($urandom_range(0, 1));
            imem_rdata          = $urandom;
            @(negedge CLK);
        end
        exec_ack   = 1'b0;
        imem_ready = 1'b0;
        taken    = ub | (cb & z);
        mPc      = taken ? mPc + imm * 64'd4 : mPc + 64'd4;
        mRetired = mRetired + 32'd1;
        checkVal("ack_retired", retired, mRetired);
        checkVal("ack_ivalid", instr_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [63:0] imm;
        mPc = PC_RESET;
        mRetired = 32'h0;
        @(negedge CLK);
        checkVal("rst_state", fsmState, IDLE);
        resetPulse(1'b0);

        // Zero-wait fetch, sequential retire.
        checkVal("first_addr", imem_addr, 64'h0);
        fetchInstr(32'h8B02_0020, 0);
        checkVal("first_opcode", opcode, 11'b10001011000);
        ackInstr(0, 0, 0, 0, 64'h0);
        checkVal("second_addr", imem_addr, 64'h4);
        checkVal("retired_one", retired, 1);

        // Memory ready after three wait cycles: req high for exactly four cycles.
        fetchInstr(32'h1234_5678, 3);
        ackInstr(2, 0, 0, 0, 64'h0);

        // Branch cases from pc 0x40.
        fetchInstr(32'hAAAA_0001, 1);
        ackInstr(0, 1, 0, 0, 64'd14);
        checkVal("br_to_40", imem_addr, 64'h40);
        fetchInstr(32'hAAAA_0002, 0);
        ackInstr(0, 1, 0, 0, -64'sd4);
        checkVal("br_uncond_neg", imem_addr, 64'h30);
        fetchInstr(32'hAAAA_0003, 0);
        ackInstr(0, 1, 0, 0, 64'd4);
        fetchInstr(32'hAAAA_0004, 0);
        ackInstr(1, 0, 1, 0, 64'd8);
        checkVal("br_cond_not_taken", imem_addr, 64'h44);
        fetchInstr(32'hAAAA_0005, 0);
        ackInstr(0, 1, 1, 0, -64'sd1);
        checkVal("br_both_high", imem_addr, 64'h40);
        fetchInstr(32'hAAAA_0006, 0);
        ackInstr(0, 0, 1, 1, 64'd8);
        checkVal("br_cond_taken", imem_addr, 64'h60);

        // Wrap of the top word address back to zero.
        fetchInstr(32'hBBBB_0001, 0);
        ackInstr(0, 1, 0, 0, -64'sd25);
        checkVal("wrap_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        fetchInstr(32'hBBBB_0002, 2);
        ackInstr(0, 0, 0, 0, 64'h0);
        checkVal("wrap_zero", imem_addr, 64'h0);

        // Reset during FETCH with a late ready seen in IDLE.
        checkVal("mid_fetch_req", imem_req, 1);
        imem_ready = 1'b0;
        @(negedge CLK);
        resetPulse(1'b1);
        checkVal("after_fetch_rst_retired", retired, 0);
        fetchInstr(32'hCCCC_0001, 0);
        ackInstr(0, 0, 0, 0, 64'h0);

        // Reset during ISSUE with ack pending: the instruction must not retire.
        fetchInstr(32'hCCCC_0002, 1);
        exec_ack = 1'b1;
        resetPulse(1'b0);
        checkVal("issue_rst_retired", retired, 0);
        checkVal("issue_rst_pc", imem_addr, PC_RESET);

        // Randomized fetch/execute traffic.
        for (int n = 0; n < 40; n++) begin
            w = $urandom;
            if (w == DEFAULT_HALT_WORD) w = 32'h1;
            imm = 64'($signed($urandom_range(0, 64)) - 32);
            fetchInstr(w, $urandom_range(0, 3));
            ackInstr($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), imm);
        end

        // Halt word stops the stage; ready and ack are ignored afterwards.
        fetchInstr(DEFAULT_HALT_WORD, 1);
        for (int i = 0; i < 20; i++) begin
            exec_ack            = 1'($urandom_range(0, 1));
            imem_ready          = 1'($urandom_range(0, 1));
            imem_rdata          = $urandom;
            unconditionalBranch = 1'($urandom_range(0, 1));
            @(negedge CLK);
            checkVal("halt_hold", halted, 1);
            checkVal("halt_req", imem_req, 0);
            checkVal("halt_valid", instr_valid, 0);
            checkVal("halt_retired", retired, mRetired);
            checkVal("halt_pc", imem_addr, mPc);
        end
        resetPulse(1'b0);
        checkVal("post_halt_clear", halted, 0);
        fetchInstr(32'hDDDD_0001, 0);
        ackInstr(0, 0, 0, 0, 64'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
